compressed_aligner: RTL and testbench
=====================================

Name: compressed_aligner

Overview:
- Fetch-side realigner directly upstream of the compressed-instruction classifier and decompressor.
- Accepts 32-bit word-aligned fetch words holding any mix of 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Emits one instruction per handshake: low-aligned in a 32-bit field, with its PC, a compressed flag and a straddle flag. The downstream half/full tracking consumes these.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 1 selects a halfword start.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  redirect; highest priority, synchronous
- flush_pc_i  in  32  redirect target, halfword aligned; bit 0 ignored
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  aligner accepts the fetch word this cycle
- fetch_data_i  in  32  fetch word at the next sequential word address
- inst_valid_o  out  1  output instruction valid (registered)
- inst_ready_i  in  1  downstream accepts the instruction
- inst_o  out  32  instruction; compressed instructions in [15:0], [31:16]=0
- inst_pc_o  out  32  PC of inst_o
- inst_compressed_o  out  1  inst_o[1:0]!=2'b11
- straddle_o  out  1  instruction assembled from two fetch words

Behaviour:
- Halfword H is 32-bit-start iff H[1:0]==2'b11; otherwise it is compressed.
- Registers: state, hbuf[15:0], pc[31:0], and the output register.
- Output slot free: free = !inst_valid_o || inst_ready_i.
- fetch_ready_o = !reset && !flush_i && free && (state!=S_HCOMP).
- Fetch accept: fire = fetch_valid_i && fetch_ready_o.
- States, transitions on fire unless noted; W = fetch_data_i, Lo = W[15:0], Hi = W[31:16]:
  - S_ALIGN:
    - Lo 32-bit-start: emit W, pc+=4, stay.
    - Lo compressed: emit Lo, pc+=2, hbuf<=Hi; Hi compressed -> S_HCOMP, else -> S_HFULL.
  - S_HCOMP (no fetch accepted): when free, emit hbuf compressed, pc+=2 -> S_ALIGN.
  - S_HFULL:
    - Always emit {Lo,hbuf}, straddle=1, pc+=4; hbuf<=Hi.
    - Hi compressed -> S_HCOMP, else stay S_HFULL.
  - S_SKIP (after halfword-target redirect), Lo discarded:
    - Hi compressed: emit Hi, pc+=2 -> S_ALIGN.
    - Hi 32-bit-start: hbuf<=Hi, no emit -> S_HFULL.
- Emit means the output register loads in the same cycle as fire, with inst_valid_o=1 the next cycle. Latency is one cycle from fetch accept to inst_valid_o.
- inst_pc_o is the pre-increment pc. straddle_o=0 except for S_HFULL emits.
- The output holds stable while inst_valid_o && !inst_ready_i.
- If inst_ready_i is high and nothing is emitted, inst_valid_o falls.
- Flush (any state, any handshake):
  - Next cycle: inst_valid_o=0, hbuf invalid, pc<=flush_pc_i & ~1.
  - Next state: S_SKIP if flush_pc_i[1], else S_ALIGN.
  - fetch_ready_o=0 during the flush cycle, so no word is consumed. A pending output is dropped even if inst_ready_i=1.
- Reset values:
  - state=S_ALIGN, pc=RESET_PC, hbuf=0.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_compressed_o=0, straddle_o=0.
  - fetch_ready_o=0 while reset is high.
- If RESET_PC[1]=1, the reset state is S_SKIP instead.
- Reset mid-stream discards hbuf and the output immediately (asynchronous).
- pc arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFE to 0 is legal.
- No fetch_valid_i in S_ALIGN/S_HFULL/S_SKIP: no state change. In S_HFULL the buffered half waits indefinitely.

Optional Feature:
- Macro: ALIGNER_PERF_CNT_EN.
- Defined:
  - Adds output straddle_cnt_o[15:0].
  - Increments on each emitted straddle instruction and saturates at 16'hFFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter absent; behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0, inst_ready_i=1. Words 32'h00A00093, 32'h00108113 -> two outputs at pc 0x0 and 0x4, compressed=0, straddle=0, one cycle after each accept.
- Word 32'h00014501 (c.li, c.nop) -> out 0x4501 pc 0x0. Then fetch_ready_o=0 for one cycle; out 0x0001 pc 0x2, compressed=1.
- Word 32'h00934505, then word 32'h45010000 -> out 0x4505 pc 0x0. Then out 32'h00000093 pc 0x2 with straddle=1. Then out 0x4501 pc 0x6.
- Flush to 0x102, then word 32'h45850000 -> out 0x4585 pc 0x102, Lo dropped. With 32'h00930000 (Hi 32-bit-start), nothing emits until the next word.
- Hold inst_ready_i=0 with valid output -> inst_* stable and fetch_ready_o=0. Assert flush_i -> inst_valid_o=0 next cycle. Assert reset mid-S_HFULL -> all outputs zero, state S_ALIGN.
- ALIGNER_PERF_CNT_EN: 3 straddle instructions -> straddle_cnt_o=3. Flush -> still 3. Reset -> 0.

Source files
------------

// File: rtl/compressed_aligner.sv
// Realigns word-aligned fetch data into one RVC or 32-bit instruction per handshake, stitching straddlers.
// Optional straddle counter output under `ifdef ALIGNER_PERF_CNT_EN.
module compressed_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_data_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_compressed_o,
   output logic        straddle_o
`ifdef ALIGNER_PERF_CNT_EN
   ,
   output logic [15:0] straddle_cnt_o
`endif
);

   localparam logic [1:0] S_ALIGN = 2'd0;
   localparam logic [1:0] S_HCOMP = 2'd1;
   localparam logic [1:0] S_HFULL = 2'd2;
   localparam logic [1:0] S_SKIP  = 2'd3;

   localparam logic [1:0] RESET_STATE = RESET_PC[1] ? S_SKIP : S_ALIGN;

   logic [1:0]  state;
   logic [15:0] hbuf;
   logic [31:0] pc;

   logic [1:0]  state_nxt;
   logic [15:0] hbuf_nxt;
   logic [31:0] pc_nxt;

   logic        emit;
   logic        emit_straddle;
   logic [31:0] emit_inst;

   logic        free;
   logic        fire;
   logic [15:0] w_lo;
   logic [15:0] w_hi;

   logic        unused_flush_pc_lsb;

   function automatic logic is_full(input logic [15:0] h);
      return h[1:0] == 2'b11;
   endfunction

   assign w_lo = fetch_data_i[15:0];
   assign w_hi = fetch_data_i[31:16];

   assign free          = !inst_valid_o || inst_ready_i;
   assign fetch_ready_o = !reset && !flush_i && free && (state != S_HCOMP);
   assign fire          = fetch_valid_i && fetch_ready_o;

   // Redirect targets are halfword aligned; the byte bit carries no information.
   assign unused_flush_pc_lsb = flush_pc_i[0];

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_nxt     = state;
      hbuf_nxt      = hbuf;
      pc_nxt        = pc;
      emit          = 1'b0;
      emit_straddle = 1'b0;
      emit_inst     = '0;
      case (state)
         S_ALIGN: begin
            if (fire) begin
               emit = 1'b1;
               if (is_full(w_lo)) begin
                  emit_inst = fetch_data_i;
                  pc_nxt    = pc + 32'd4;
               end else begin
                  emit_inst = {16'h0000, w_lo};
                  pc_nxt    = pc + 32'd2;
                  hbuf_nxt  = w_hi;
                  state_nxt = is_full(w_hi) ? S_HFULL : S_HCOMP;
               end
            end
         end
         S_HCOMP: begin
            // The buffered RVC half drains without consuming a fetch word.
            if (free) begin
               emit      = 1'b1;
               emit_inst = {16'h0000, hbuf};
               pc_nxt    = pc + 32'd2;
               state_nxt = S_ALIGN;
            end
         end
         S_HFULL: begin
            if (fire) begin
               emit          = 1'b1;
               emit_straddle = 1'b1;
               emit_inst     = {w_lo, hbuf};
               pc_nxt        = pc + 32'd4;
               hbuf_nxt      = w_hi;
               state_nxt     = is_full(w_hi) ? S_HFULL : S_HCOMP;
            end
         end
         default: begin
            // S_SKIP: the low half precedes the redirect target and is dropped.
            if (fire) begin
               if (is_full(w_hi)) begin
                  hbuf_nxt  = w_hi;
                  state_nxt = S_HFULL;
               end else begin
                  emit      = 1'b1;
                  emit_inst = {16'h0000, w_hi};
                  pc_nxt    = pc + 32'd2;
                  state_nxt = S_ALIGN;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
         hbuf  <= '0;
         pc    <= RESET_PC;
      end else if (flush_i) begin
         state <= flush_pc_i[1] ? S_SKIP : S_ALIGN;
         hbuf  <= '0;
         pc    <= {flush_pc_i[31:1], 1'b0};
      end else begin
         state <= state_nxt;
         hbuf  <= hbuf_nxt;
         pc    <= pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_valid_o      <= 1'b0;
         inst_o            <= '0;
         inst_pc_o         <= '0;
         inst_compressed_o <= 1'b0;
         straddle_o        <= 1'b0;
      end else if (flush_i) begin
         inst_valid_o <= 1'b0;
      end else if (emit) begin
         inst_valid_o      <= 1'b1;
         inst_o            <= emit_inst;
         inst_pc_o         <= pc;
         inst_compressed_o <= emit_inst[1:0] != 2'b11;
         straddle_o        <= emit_straddle;
      end else if (inst_ready_i) begin
         inst_valid_o <= 1'b0;
      end
   end

`ifdef ALIGNER_PERF_CNT_EN
   // Saturating count of emitted straddlers; survives redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         straddle_cnt_o <= '0;
      end else if (emit_straddle && !flush_i && (straddle_cnt_o != 16'hFFFF)) begin
         straddle_cnt_o <= straddle_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_compressed_aligner.sv
// Scoreboard bench for compressed_aligner: a halfword-stream parser predicts the instruction sequence.
module tb_compressed_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic [31:0] fetch_data_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_compressed_o;
   logic        straddle_o;
`ifdef ALIGNER_PERF_CNT_EN
   logic [15:0] straddle_cnt_o;
`endif

   always #5 clk = ~clk;

   compressed_aligner #(.RESET_PC(RESET_PC)) dut (
      .clk               (clk),
      .reset             (reset),
      .flush_i           (flush_i),
      .flush_pc_i        (flush_pc_i),
      .fetch_valid_i     (fetch_valid_i),
      .fetch_ready_o     (fetch_ready_o),
      .fetch_data_i      (fetch_data_i),
      .inst_valid_o      (inst_valid_o),
      .inst_ready_i      (inst_ready_i),
      .inst_o            (inst_o),
      .inst_pc_o         (inst_pc_o),
      .inst_compressed_o (inst_compressed_o),
      .straddle_o        (straddle_o)
`ifdef ALIGNER_PERF_CNT_EN
      ,
      .straddle_cnt_o    (straddle_cnt_o)
`endif
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        comp;
      logic        strad;
   } exp_t;

   int          total = 0;
   int          bad = 0;

   // Reference model: a stream of halfwords starting at mpc, parsed by the ISA length rule.
   logic [15:0] hq[$];
   exp_t        exp_q[$];
   logic [31:0] mpc;
   logic        mskip;
   logic [15:0] mcnt;

   bit          accepted;
   bit          rand_ready = 1'b0;

   logic        stall_prev = 1'b0;
   logic [31:0] s_inst;
   logic [31:0] s_pc;
   logic        s_comp;
   logic        s_strad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hq.delete();
      exp_q.delete();
      mpc   = RESET_PC & ~32'd1;
      mskip = RESET_PC[1];
      mcnt  = '0;
   endfunction

   function automatic void model_flush(input logic [31:0] t);
      hq.delete();
      exp_q.delete();
      mpc   = t & ~32'd1;
      mskip = t[1];
   endfunction

   function automatic void model_parse();
      exp_t        e;
      logic [15:0] h0;
      while (hq.size() > 0) begin
         h0 = hq[0];
         if (h0[1:0] != 2'b11) begin
            e.inst  = {16'h0000, h0};
            e.pc    = mpc;
            e.comp  = 1'b1;
            e.strad = 1'b0;
            exp_q.push_back(e);
            mpc = mpc + 32'd2;
            void'(hq.pop_front());
         end else if (hq.size() >= 2) begin
            e.inst  = {hq[1], h0};
            e.pc    = mpc;
            e.comp  = 1'b0;
            // An instruction starting at an odd halfword must span two words.
            e.strad = mpc[1];
            if (e.strad && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            exp_q.push_back(e);
            mpc = mpc + 32'd4;
            void'(hq.pop_front());
            void'(hq.pop_front());
         end else begin
            break;
         end
      end
   endfunction

   function automatic void model_accept(input logic [31:0] w);
      if (!mskip) hq.push_back(w[15:0]);
      hq.push_back(w[31:16]);
      mskip = 1'b0;
      model_parse();
   endfunction

   // One clock: observe the handshake at negedge, return just after the next posedge.
   task automatic tick();
      @(negedge clk);
      if (!reset) begin
         if (flush_i) begin
            model_flush(flush_pc_i);
         end else if (fetch_valid_i && fetch_ready_o) begin
            model_accept(fetch_data_i);
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n;
      n = 0;
      fetch_valid_i = 1'b1;
      fetch_data_i  = w;
      accepted      = 1'b0;
      while (!accepted && n < 64) begin
         if (rand_ready) inst_ready_i = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      fetch_valid_i = 1'b0;
      check1("accept_in_time", accepted, 1'b1);
   endtask

   task automatic do_flush(input logic [31:0] t);
      fetch_valid_i = 1'b0;
      flush_i       = 1'b1;
      flush_pc_i    = t;
      tick();
      flush_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      inst_ready_i = 1'b1;
      while (exp_q.size() > 0 && n < 32) begin
         tick();
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      fetch_valid_i = 1'b0;
      flush_i       = 1'b0;
      model_reset();
      #1;
      check1("rst_valid", inst_valid_o, 1'b0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_pc", inst_pc_o, 32'h0);
      check1("rst_comp", inst_compressed_o, 1'b0);
      check1("rst_strad", straddle_o, 1'b0);
      check1("rst_fready", fetch_ready_o, 1'b0);
`ifdef ALIGNER_PERF_CNT_EN
      check("rst_cnt", 32'(straddle_cnt_o), 32'h0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   // Monitor: pops an expectation on every accepted output, and checks hold behaviour under stall.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else if (flush_i) begin
            check1("ready_in_flush", fetch_ready_o, 1'b0);
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check1("hold_valid", inst_valid_o, 1'b1);
               check("hold_inst", inst_o, s_inst);
               check("hold_pc", inst_pc_o, s_pc);
               check1("hold_comp", inst_compressed_o, s_comp);
               check1("hold_strad", straddle_o, s_strad);
            end
            if (inst_valid_o && !inst_ready_i) check1("ready_in_stall", fetch_ready_o, 1'b0);
            if (inst_valid_o && inst_ready_i) begin
               check1("out_pending", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("out_inst", inst_o, e.inst);
                  check("out_pc", inst_pc_o, e.pc);
                  check1("out_comp", inst_compressed_o, e.comp);
                  check1("out_strad", straddle_o, e.strad);
               end
            end
            stall_prev = inst_valid_o && !inst_ready_i;
            s_inst     = inst_o;
            s_pc       = inst_pc_o;
            s_comp     = inst_compressed_o;
            s_strad    = straddle_o;
         end
      end
   end

   initial begin : driver
      flush_i       = 1'b0;
      flush_pc_i    = '0;
      fetch_valid_i = 1'b0;
      fetch_data_i  = '0;
      inst_ready_i  = 1'b1;
      #2;
      do_reset();

      // Two aligned 32-bit instructions, each one cycle after accept.
      send_word(32'h00A00093);
      check1("t1_lat0", inst_valid_o, 1'b1);
      check("t1_inst0", inst_o, 32'h00A00093);
      send_word(32'h00108113);
      check1("t1_lat1", inst_valid_o, 1'b1);
      check("t1_pc1", inst_pc_o, 32'h4);
      drain();

      // Two RVC in one word: second drains while fetch is held off.
      do_reset();
      send_word(32'h00014501);
      check("t2_inst0", inst_o, 32'h4501);
      check1("t2_hcomp_noready", fetch_ready_o, 1'b0);
      tick();
      check("t2_inst1", inst_o, 32'h0001);
      check("t2_pc1", inst_pc_o, 32'h2);
      check1("t2_comp1", inst_compressed_o, 1'b1);
      drain();

      // RVC followed by a straddling 32-bit instruction, then RVC.
      do_reset();
      send_word(32'h00934505);
      check("t3_inst0", inst_o, 32'h4505);
      send_word(32'h45010000);
      check("t3_inst1", inst_o, 32'h00000093);
      check("t3_pc1", inst_pc_o, 32'h2);
      check1("t3_strad1", straddle_o, 1'b1);
      tick();
      check("t3_inst2", inst_o, 32'h4501);
      check("t3_pc2", inst_pc_o, 32'h6);
      drain();

      // Halfword redirect targets.
      do_flush(32'h0000_0102);
      send_word(32'h45850000);
      check("t4_inst0", inst_o, 32'h4585);
      check("t4_pc0", inst_pc_o, 32'h102);
      do_flush(32'h0000_0102);
      send_word(32'h00930000);
      check1("t4_no_emit", inst_valid_o, 1'b0);
      send_word(32'h00010000);
      check("t4_inst1", inst_o, 32'h00000093);
      check1("t4_strad1", straddle_o, 1'b1);
      drain();

      // Backpressure, flush of a pending output, reset in the middle of a straddle.
      do_reset();
      inst_ready_i = 1'b0;
      send_word(32'h00A00093);
      repeat (3) tick();
      check1("t5_hold_valid", inst_valid_o, 1'b1);
      check1("t5_hold_fready", fetch_ready_o, 1'b0);
      do_flush(32'h0000_0040);
      check1("t5_flush_drop", inst_valid_o, 1'b0);
      inst_ready_i = 1'b1;
      send_word(32'h00934505);
      check("t5_pc_after_flush", inst_pc_o, 32'h40);
      repeat (2) tick();
      do_reset();
      send_word(32'h00A00093);
      check("t5_post_rst_pc", inst_pc_o, 32'h0);
      check1("t5_post_rst_strad", straddle_o, 1'b0);
      drain();

`ifdef ALIGNER_PERF_CNT_EN
      do_reset();
      send_word(32'h00934505);
      send_word(32'h00930000);
      send_word(32'h00930000);
      send_word(32'h00010000);
      drain();
      check("t6_cnt", 32'(straddle_cnt_o), 32'd3);
      do_flush(32'h0);
      check("t6_cnt_flush", 32'(straddle_cnt_o), 32'd3);
`endif

      // Randomised stream with random backpressure, redirects and wrap-around targets.
      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 2) == 0) do_flush(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            else do_flush($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            fetch_valid_i = 1'b0;
            inst_ready_i  = ($urandom_range(0, 1) != 0);
            tick();
         end else begin
            send_word({rand_half(), rand_half()});
         end
      end
      rand_ready = 1'b0;
      drain();
`ifdef ALIGNER_PERF_CNT_EN
      check("rand_cnt", 32'(straddle_cnt_o), 32'(mcnt));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
